// File: rtl/pixel_cfg_sequencer.sv
// Turns a header + payload word stream into one-cycle pixel config writes, with GAP idle cycles between payloads.
// Latency: one cycle from payload accept to cfg_valid. Backpressure: s_ready is low during the GAP cycles and during reset.
module pixel_cfg_sequencer #(
    parameter int NPIX = 180,
    parameter int GAP  = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  cfg_addr,
    output logic [14:0] cfg_data,
    output logic        cfg_valid,
    output logic        busy,
    output logic        done,
    output logic        err_addr,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAPW = 2'd2
    } state_t;

    localparam logic [3:0] GAP_L  = 4'(GAP);
    localparam logic [8:0] NPIX_L = 9'(NPIX);

    state_t      state;
    state_t      state_nxt;
    logic        rdy_en;
    logic [7:0]  addr;
    logic [8:0]  cnt;
    logic [3:0]  gap_cnt;

    logic        acc;
    logic        hdr_acc;
    logic        pay_acc;
    logic        last_pay;
    logic        in_range;

    // rdy_en holds s_ready low until the first edge after reset release.
    assign s_ready  = rdy_en && (state != GAPW);
    assign busy     = (state != IDLE);
    assign acc      = s_valid && s_ready;
    assign hdr_acc  = acc && (state == IDLE);
    assign pay_acc  = acc && (state == DATA);
    assign last_pay = pay_acc && (cnt == 9'd1);
    assign in_range = ({1'b0, addr} < NPIX_L);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hdr_acc) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (pay_acc) begin
                    if (last_pay) begin
                        state_nxt = IDLE;
                    end else if (GAP_L != 4'd0) begin
                        state_nxt = GAPW;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            GAPW: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = DATA;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdy_en    <= 1'b0;
            addr      <= 8'd0;
            cnt       <= 9'd0;
            gap_cnt   <= 4'd0;
            cfg_valid <= 1'b0;
            cfg_addr  <= 8'd0;
            cfg_data  <= 15'd0;
            done      <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            cfg_valid <= 1'b0;
            done      <= last_pay;
            if (hdr_acc) begin
                addr <= s_data[15:8];
                cnt  <= {1'b0, s_data[7:0]} + 9'd1;
            end
            if (pay_acc) begin
                addr <= addr + 8'd1;
                cnt  <= cnt - 9'd1;
                if (in_range) begin
                    cfg_valid <= 1'b1;
                    cfg_addr  <= addr;
                    cfg_data  <= s_data[14:0];
                end
            end
            // Loaded with GAP-1 so GAPW lasts exactly GAP cycles.
            if (pay_acc && !last_pay) begin
                gap_cnt <= GAP_L - 4'd1;
            end else if ((state == GAPW) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    // A new suppressed write outranks a coincident clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_addr <= 1'b0;
        end else if (pay_acc && !in_range) begin
            err_addr <= 1'b1;
        end else if (err_clr) begin
            err_addr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_cfg_sequencer.sv
// Directed bench: per-cycle vector table for a gapped frame, plus hand sequences for range, wrap, reset and GAP=0.
module tb_pixel_cfg_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] s_data;
    logic        s_valid;
    logic        err_clr;

    logic        s_ready, cfg_valid, busy, done, err_addr;
    logic [7:0]  cfg_addr;
    logic [14:0] cfg_data;

    logic        z_ready, z_valid, z_busy, z_done, z_err;
    logic [7:0]  z_addr;
    logic [14:0] z_data;

    always #5 clock = ~clock;

    pixel_cfg_sequencer #(.NPIX(180), .GAP(2)) dut (
        .clock(clock), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .busy(busy), .done(done), .err_addr(err_addr),
        .err_clr(err_clr)
    );

    pixel_cfg_sequencer #(.NPIX(180), .GAP(0)) dut_z (
        .clock(clock), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
        .s_ready(z_ready), .cfg_addr(z_addr), .cfg_data(z_data),
        .cfg_valid(z_valid), .busy(z_busy), .done(z_done), .err_addr(z_err),
        .err_clr(err_clr)
    );

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        rdy;
        logic        cv;
        logic [7:0]  ca;
        logic [14:0] cd;
        logic        bsy;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl[13];

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  q_addr[$];
    logic [14:0] q_data[$];
    int          n_done = 0;
    logic        done_cv = 1'b0;

    always @(negedge clock) begin
        if (cfg_valid) begin
            q_addr.push_back(cfg_addr);
            q_data.push_back(cfg_data);
        end
        if (done) begin
            n_done++;
            done_cv = cfg_valid;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        int t;
        t = 0;
        s_data  = w;
        s_valid = 1'b1;
        #1;
        while (!s_ready && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: s_ready stayed 0 for word %0h", w);
        end
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        n_done  = 0;
        done_cv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Header 0x0503 then four payloads with s_valid held, GAP=2.
        tbl[0]  = '{1'b1, 16'h0503, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 8'h05, 15'h1111, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 8'h05, 15'h1111, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 8'h05, 15'h1111, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h3333, 1'b0, 1'b1, 8'h06, 15'h2222, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 8'h06, 15'h2222, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h3333, 1'b1, 1'b0, 8'h06, 15'h2222, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h4444, 1'b0, 1'b1, 8'h07, 15'h3333, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 8'h07, 15'h3333, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h4444, 1'b1, 1'b0, 8'h07, 15'h3333, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h08, 15'h4444, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h08, 15'h4444, 1'b0, 1'b0, 1'b0};

        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        err_clr = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst s_ready",   32'(s_ready),   32'h0);
        chk("rst cfg_valid", 32'(cfg_valid), 32'h0);
        chk("rst cfg_addr",  32'(cfg_addr),  32'h0);
        chk("rst cfg_data",  32'(cfg_data),  32'h0);
        chk("rst busy",      32'(busy),      32'h0);
        chk("rst done",      32'(done),      32'h0);
        chk("rst err_addr",  32'(err_addr),  32'h0);
        resetn = 1'b1;
        #1;
        chk("rel s_ready before edge", 32'(s_ready), 32'h0);
        @(negedge clock);
        #1;
        chk("rel s_ready after edge", 32'(s_ready), 32'h1);

        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            s_valid = tbl[i].vld;
            s_data  = tbl[i].dat;
            #1;
            chk($sformatf("v%0d s_ready", i),   32'(s_ready),   32'(tbl[i].rdy));
            chk($sformatf("v%0d cfg_valid", i), 32'(cfg_valid), 32'(tbl[i].cv));
            chk($sformatf("v%0d cfg_addr", i),  32'(cfg_addr),  32'(tbl[i].ca));
            chk($sformatf("v%0d cfg_data", i),  32'(cfg_data),  32'(tbl[i].cd));
            chk($sformatf("v%0d busy", i),      32'(busy),      32'(tbl[i].bsy));
            chk($sformatf("v%0d done", i),      32'(done),      32'(tbl[i].dn));
            chk($sformatf("v%0d err_addr", i),  32'(err_addr),  32'(tbl[i].er));
        end

        // Start at 178, three words: 180 is out of range.
        @(negedge clock);
        clear_mon();
        send(16'hB202);
        send(16'h0AAA);
        send(16'h0BBB);
        send(16'h0CCC);
        settle();
        chk("range nwrites", 32'(q_addr.size()), 32'd2);
        chk("range w0 addr", 32'(q_addr[0]), 32'd178);
        chk("range w0 data", 32'(q_data[0]), 32'h0AAA);
        chk("range w1 addr", 32'(q_addr[1]), 32'd179);
        chk("range w1 data", 32'(q_data[1]), 32'h0BBB);
        chk("range err_addr", 32'(err_addr), 32'h1);
        chk("range ndone", 32'(n_done), 32'd1);
        chk("range done_with_write", 32'(done_cv), 32'h0);
        chk("range hold addr", 32'(cfg_addr), 32'd179);
        chk("range busy", 32'(busy), 32'h0);

        // Set and clear in the same cycle: set wins; clear alone next cycle.
        send(16'hB400);
        s_data  = 16'h0123;
        s_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        #1;
        chk("clr+set err_addr", 32'(err_addr), 32'h1);
        chk("clr+set done", 32'(done), 32'h1);
        chk("clr+set cfg_valid", 32'(cfg_valid), 32'h0);
        @(negedge clock);
        err_clr = 1'b0;
        #1;
        chk("clr alone err_addr", 32'(err_addr), 32'h0);

        // Start at 255: suppressed, then wraps to 0; payload bit 15 is dropped.
        clear_mon();
        send(16'hFF01);
        send(16'h1234);
        send(16'h8ABC);
        settle();
        chk("wrap nwrites", 32'(q_addr.size()), 32'd1);
        chk("wrap w0 addr", 32'(q_addr[0]), 32'd0);
        chk("wrap w0 data", 32'(q_data[0]), 32'h0ABC);
        chk("wrap err_addr", 32'(err_addr), 32'h1);
        chk("wrap ndone", 32'(n_done), 32'd1);
        chk("wrap done_with_write", 32'(done_cv), 32'h1);

        // Reset after two of four payloads.
        clear_mon();
        send(16'h1003);
        send(16'h0101);
        send(16'h0202);
        @(negedge clock);
        #2;
        resetn  = 1'b0;
        s_data  = 16'h0303;
        s_valid = 1'b1;
        #1;
        chk("midrst s_ready",   32'(s_ready),   32'h0);
        chk("midrst cfg_valid", 32'(cfg_valid), 32'h0);
        chk("midrst cfg_addr",  32'(cfg_addr),  32'h0);
        chk("midrst cfg_data",  32'(cfg_data),  32'h0);
        chk("midrst busy",      32'(busy),      32'h0);
        chk("midrst done",      32'(done),      32'h0);
        chk("midrst err_addr",  32'(err_addr),  32'h0);
        repeat (2) @(negedge clock);
        s_valid = 1'b0;
        resetn  = 1'b1;
        settle();
        chk("midrst nwrites", 32'(q_addr.size()), 32'd2);
        send(16'h2000);
        send(16'h0055);
        settle();
        chk("postrst nwrites", 32'(q_addr.size()), 32'd3);
        chk("postrst addr", 32'(q_addr[2]), 32'h20);
        chk("postrst data", 32'(q_data[2]), 32'h0055);

        // GAP=0 instance, s_valid toggling around a one-word frame.
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        #1;
        chk("g0 idle s_ready", 32'(z_ready), 32'h1);
        chk("g0 idle busy", 32'(z_busy), 32'h0);
        @(negedge clock);
        s_valid = 1'b1;
        s_data  = 16'h0000;
        #1;
        chk("g0 hdr s_ready", 32'(z_ready), 32'h1);
        @(negedge clock);
        s_valid = 1'b0;
        #1;
        chk("g0 wait s_ready", 32'(z_ready), 32'h1);
        chk("g0 wait busy", 32'(z_busy), 32'h1);
        chk("g0 wait cfg_valid", 32'(z_valid), 32'h0);
        @(negedge clock);
        s_valid = 1'b1;
        s_data  = 16'h7FFF;
        #1;
        chk("g0 pay cfg_valid", 32'(z_valid), 32'h0);
        @(negedge clock);
        s_valid = 1'b0;
        #1;
        chk("g0 out cfg_valid", 32'(z_valid), 32'h1);
        chk("g0 out cfg_addr", 32'(z_addr), 32'h00);
        chk("g0 out cfg_data", 32'(z_data), 32'h7FFF);
        chk("g0 out done", 32'(z_done), 32'h1);
        chk("g0 out busy", 32'(z_busy), 32'h0);
        chk("g0 out s_ready", 32'(z_ready), 32'h1);
        @(negedge clock);
        #1;
        chk("g0 after cfg_valid", 32'(z_valid), 32'h0);
        chk("g0 after done", 32'(z_done), 32'h0);
        chk("g0 after hold data", 32'(z_data), 32'h7FFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
